conv_mem_responder: RTL and testbench

- Synthesizable memory-side responder for the CONV engine.
- Holds the 64x64 input image and serves it on iaddr/idata.
- Hosts the five layer buffers selected by csel (L0 kernel0/1, L1 kernel0/1, L2 flatten) and serves cwr writes and crd reads.
- A small host-side controller loads the image, raises ready, tracks busy and flags completion, so CONV can run on-chip without the simulation fixture.

---
 rtl/conv_mem_responder.sv | 148 ++++++++++++++
 tb/tb_conv_mem_responder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mem_responder.sv
// Memory-side responder for the CONV engine: image store, five layer banks and
// the host handshake FSM that loads the image, raises ready and reports done.
module conv_mem_responder #(
    parameter int DW   = 20,
    parameter int IAW  = 12,
    parameter int L1AW = 10,
    parameter int L2AW = 11
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            host_wr,
    input  logic [IAW-1:0]  host_addr,
    input  logic [DW-1:0]   host_data,
    input  logic            host_start,
    output logic            host_done,
    output logic            ready,
    input  logic            busy,
    input  logic [IAW-1:0]  iaddr,
    output logic [DW-1:0]   idata,
    input  logic            cwr,
    input  logic [IAW-1:0]  caddr_wr,
    input  logic [DW-1:0]   cdata_wr,
    input  logic            crd,
    input  logic [IAW-1:0]  caddr_rd,
    output logic [DW-1:0]   cdata_rd,
    input  logic [2:0]      csel,
    output logic [2:0]      wr_flags
);

    typedef enum logic [1:0] {S_IDLE, S_READY, S_RUN, S_DONE} state_t;

    state_t state_q, state_d;

    logic [DW-1:0] img_mem  [0:(1<<IAW)-1];
    logic [DW-1:0] l0k0_mem [0:(1<<IAW)-1];
    logic [DW-1:0] l0k1_mem [0:(1<<IAW)-1];
    logic [DW-1:0] l1k0_mem [0:(1<<L1AW)-1];
    logic [DW-1:0] l1k1_mem [0:(1<<L1AW)-1];
    logic [DW-1:0] l2_mem   [0:(1<<L2AW)-1];

    logic [DW-1:0] idata_q, cdata_rd_q, cdata_rd_d;
    logic [2:0]    wr_flags_q, wr_flags_d;
    logic [DW-1:0] rd_word;
    logic          wr_hit;
    logic [2:0]    flag_set;
    logic          img_we;

    always_comb begin
        state_d   = state_q;
        ready     = 1'b0;
        host_done = 1'b0;
        case (state_q)
            S_IDLE:  if (host_start) state_d = S_READY;
            S_READY: begin
                ready = 1'b1;
                if (busy) state_d = S_RUN;
            end
            S_RUN:   if (!busy) state_d = S_DONE;
            S_DONE:  begin
                host_done = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Image loads are only accepted while idle; CONV owns the image once started.
    assign img_we = host_wr && (state_q == S_IDLE);

    // Bank contents are deliberately never reset so partial results survive a reset.
    always_ff @(posedge clk) begin
        if (img_we) img_mem[host_addr] <= host_data;
        if (cwr) begin
            case (csel)
                3'b001: l0k0_mem[caddr_wr]             <= cdata_wr;
                3'b010: l0k1_mem[caddr_wr]             <= cdata_wr;
                3'b011: l1k0_mem[caddr_wr[L1AW-1:0]]   <= cdata_wr;
                3'b100: l1k1_mem[caddr_wr[L1AW-1:0]]   <= cdata_wr;
                3'b101: l2_mem[caddr_wr[L2AW-1:0]]     <= cdata_wr;
                default: ;
            endcase
        end
    end

    // wr_hit compares effective (bank-width) addresses so aliased writes forward too.
    always_comb begin
        rd_word  = '0;
        wr_hit   = 1'b0;
        flag_set = 3'b000;
        case (csel)
            3'b001: begin
                rd_word     = l0k0_mem[caddr_rd];
                wr_hit      = (caddr_wr == caddr_rd);
                flag_set[0] = cwr;
            end
            3'b010: begin
                rd_word     = l0k1_mem[caddr_rd];
                wr_hit      = (caddr_wr == caddr_rd);
                flag_set[0] = cwr;
            end
            3'b011: begin
                rd_word     = l1k0_mem[caddr_rd[L1AW-1:0]];
                wr_hit      = (caddr_wr[L1AW-1:0] == caddr_rd[L1AW-1:0]);
                flag_set[1] = cwr;
            end
            3'b100: begin
                rd_word     = l1k1_mem[caddr_rd[L1AW-1:0]];
                wr_hit      = (caddr_wr[L1AW-1:0] == caddr_rd[L1AW-1:0]);
                flag_set[1] = cwr;
            end
            3'b101: begin
                rd_word     = l2_mem[caddr_rd[L2AW-1:0]];
                wr_hit      = (caddr_wr[L2AW-1:0] == caddr_rd[L2AW-1:0]);
                flag_set[2] = cwr;
            end
            default: ;
        endcase
    end

    always_comb begin
        cdata_rd_d = cdata_rd_q;
        if (crd) cdata_rd_d = (cwr && wr_hit) ? cdata_wr : rd_word;
    end

    always_comb begin
        wr_flags_d = wr_flags_q | flag_set;
        if (state_q == S_IDLE && state_d == S_READY) wr_flags_d = 3'b000;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            idata_q    <= '0;
            cdata_rd_q <= '0;
            wr_flags_q <= 3'b000;
        end else begin
            state_q    <= state_d;
            idata_q    <= img_mem[iaddr];
            cdata_rd_q <= cdata_rd_d;
            wr_flags_q <= wr_flags_d;
        end
    end

    assign idata    = idata_q;
    assign cdata_rd = cdata_rd_q;
    assign wr_flags = wr_flags_q;

endmodule

// File: tb/tb_conv_mem_responder.sv
// Scoreboard bench for conv_mem_responder: a reference model of the image and
// layer banks predicts every read; predictions are queued and popped on output.
module tb_conv_mem_responder;

    logic        clk;
    logic        reset;
    logic        host_wr;
    logic [11:0] host_addr;
    logic [19:0] host_data;
    logic        host_start;
    logic        host_done;
    logic        ready;
    logic        busy;
    logic [11:0] iaddr;
    logic [19:0] idata;
    logic        cwr;
    logic [11:0] caddr_wr;
    logic [19:0] cdata_wr;
    logic        crd;
    logic [11:0] caddr_rd;
    logic [19:0] cdata_rd;
    logic [2:0]  csel;
    logic [2:0]  wr_flags;

    conv_mem_responder dut (
        .clk(clk), .reset(reset),
        .host_wr(host_wr), .host_addr(host_addr), .host_data(host_data),
        .host_start(host_start), .host_done(host_done),
        .ready(ready), .busy(busy),
        .iaddr(iaddr), .idata(idata),
        .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
        .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
        .csel(csel), .wr_flags(wr_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [19:0] cq[$];
    logic [19:0] iq[$];
    logic [19:0] img_mdl [int];
    logic [19:0] bank_mdl [int];
    logic [2:0]  flags_exp = 3'b000;
    logic        tb_idle = 1'b1;
    logic        ipend = 1'b0;

    task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%05h expected 0x%05h", tag, obs, exp);
        end
    endtask

    // One clock: remember which reads were launched, then compare against the queue.
    task automatic step();
        logic c, i;
        logic [19:0] e;
        c = crd;
        i = ipend;
        @(posedge clk);
        #1;
        if (c) begin
            if (cq.size() == 0) check("cq_underflow", 20'h1, 20'h0);
            else begin
                e = cq.pop_front();
                check("cdata_rd", cdata_rd, e);
            end
        end
        if (i) begin
            if (iq.size() == 0) check("iq_underflow", 20'h1, 20'h0);
            else begin
                e = iq.pop_front();
                check("idata", idata, e);
            end
        end
    endtask

    function automatic int bank_key(input logic [2:0] sel, input logic [11:0] a);
        case (sel)
            3'd3, 3'd4: return sel * 4096 + int'(a & 12'h3FF);
            3'd5:       return sel * 4096 + int'(a & 12'h7FF);
            default:    return sel * 4096 + int'(a);
        endcase
    endfunction

    function automatic logic [2:0] flag_bit(input logic [2:0] sel);
        case (sel)
            3'd1, 3'd2: return 3'b001;
            3'd3, 3'd4: return 3'b010;
            3'd5:       return 3'b100;
            default:    return 3'b000;
        endcase
    endfunction

    task automatic hwrite(input logic [11:0] a, input logic [19:0] d, input logic start);
        host_wr = 1'b1; host_addr = a; host_data = d; host_start = start;
        if (tb_idle) begin
            img_mdl[int'(a)] = d;
            if (start) begin
                flags_exp = 3'b000;
                tb_idle   = 1'b0;
            end
        end
        step();
        host_wr = 1'b0; host_start = 1'b0;
    endtask

    task automatic iread(input logic [11:0] a);
        iaddr = a;
        ipend = 1'b1;
        iq.push_back(img_mdl[int'(a)]);
        step();
        ipend = 1'b0;
    endtask

    task automatic lop(input logic [2:0] sel, input logic w, input logic [11:0] wa,
                       input logic [19:0] wd, input logic r, input logic [11:0] ra);
        csel = sel; cwr = w; caddr_wr = wa; cdata_wr = wd; crd = r; caddr_rd = ra;
        if (w && flag_bit(sel) != 3'b000) begin
            bank_mdl[bank_key(sel, wa)] = wd;
            flags_exp = flags_exp | flag_bit(sel);
        end
        if (r) begin
            if (flag_bit(sel) == 3'b000) cq.push_back(20'h0);
            else cq.push_back(bank_mdl[bank_key(sel, ra)]);
        end
        step();
        cwr = 1'b0; crd = 1'b0;
    endtask

    initial begin
        reset = 1'b0; host_wr = 1'b0; host_addr = '0; host_data = '0; host_start = 1'b0;
        busy = 1'b0; iaddr = '0; cwr = 1'b0; caddr_wr = '0; cdata_wr = '0;
        crd = 1'b0; caddr_rd = '0; csel = '0;

        // Reset and idle
        repeat (3) step();
        check("rst_ready", {19'd0, ready}, 20'h0);
        check("rst_done", {19'd0, host_done}, 20'h0);
        check("rst_cdata_rd", cdata_rd, 20'h0);
        check("rst_idata", idata, 20'h0);
        check("rst_flags", {17'd0, wr_flags}, 20'h0);
        reset = 1'b1;
        step();
        check("idle_ready", {19'd0, ready}, 20'h0);

        // Image load and start handshake
        hwrite(12'd0, 20'h00012, 1'b0);
        hwrite(12'd4095, 20'hFFFEE, 1'b1);
        check("ready_up", {19'd0, ready}, 20'h1);
        step();
        check("ready_hold", {19'd0, ready}, 20'h1);
        busy = 1'b1;
        step();
        check("ready_drop", {19'd0, ready}, 20'h0);
        iread(12'd4095);
        iread(12'd0);
        hwrite(12'd0, 20'h00999, 1'b0);
        iread(12'd0);
        host_start = 1'b1;
        step();
        host_start = 1'b0;
        check("start_in_run", {19'd0, ready}, 20'h0);

        // Bank isolation
        lop(3'd1, 1'b1, 12'h010, 20'h0ABCD, 1'b0, 12'h0);
        lop(3'd2, 1'b1, 12'h010, 20'h01234, 1'b0, 12'h0);
        lop(3'd5, 1'b1, 12'h810, 20'h05555, 1'b0, 12'h0);
        lop(3'd1, 1'b0, 12'h0, 20'h0, 1'b1, 12'h010);
        lop(3'd2, 1'b0, 12'h0, 20'h0, 1'b1, 12'h010);
        lop(3'd5, 1'b0, 12'h0, 20'h0, 1'b1, 12'h010);
        check("flags_101", {17'd0, wr_flags}, {17'd0, flags_exp});

        // Invalid select and L1 aliasing
        lop(3'd7, 1'b1, 12'h010, 20'h0DEAD, 1'b0, 12'h0);
        check("flags_inv_wr", {17'd0, wr_flags}, {17'd0, flags_exp});
        lop(3'd1, 1'b0, 12'h0, 20'h0, 1'b1, 12'h010);
        lop(3'd5, 1'b0, 12'h0, 20'h0, 1'b1, 12'h010);
        lop(3'd3, 1'b1, 12'hC05, 20'h0BEEF, 1'b0, 12'h0);
        lop(3'd3, 1'b0, 12'h0, 20'h0, 1'b1, 12'h005);
        check("flags_111", {17'd0, wr_flags}, {17'd0, flags_exp});
        lop(3'd0, 1'b0, 12'h0, 20'h0, 1'b1, 12'h010);

        // Write-first forwarding and hold
        lop(3'd4, 1'b1, 12'h3FF, 20'h7FFFF, 1'b1, 12'h3FF);
        step();
        check("rd_hold", cdata_rd, 20'h7FFFF);
        lop(3'd4, 1'b1, 12'h100, 20'h22222, 1'b1, 12'h3FF);
        lop(3'd4, 1'b0, 12'h0, 20'h0, 1'b1, 12'h100);

        // Completion pulse
        busy = 1'b0;
        step();
        check("done_pulse", {19'd0, host_done}, 20'h1);
        step();
        check("done_clear", {19'd0, host_done}, 20'h0);
        check("done_ready", {19'd0, ready}, 20'h0);
        tb_idle = 1'b1;

        // Second run interrupted by reset
        hwrite(12'd5, 20'h00055, 1'b1);
        check("run2_ready", {19'd0, ready}, 20'h1);
        check("run2_flags_clr", {17'd0, wr_flags}, {17'd0, flags_exp});
        lop(3'd1, 1'b1, 12'h020, 20'h11111, 1'b0, 12'h0);
        check("run2_flags", {17'd0, wr_flags}, {17'd0, flags_exp});
        busy = 1'b1;
        step();
        check("run2_ready_drop", {19'd0, ready}, 20'h0);
        #3 reset = 1'b0;
        flags_exp = 3'b000;
        tb_idle   = 1'b1;
        #1;
        check("arst_ready", {19'd0, ready}, 20'h0);
        check("arst_flags", {17'd0, wr_flags}, 20'h0);
        check("arst_cdata_rd", cdata_rd, 20'h0);
        busy = 1'b0;
        #2 reset = 1'b1;
        step();
        lop(3'd1, 1'b0, 12'h0, 20'h0, 1'b1, 12'h010);
        lop(3'd1, 1'b0, 12'h0, 20'h0, 1'b1, 12'h020);
        iread(12'd5);
        check("post_rst_ready", {19'd0, ready}, 20'h0);
        if (cq.size() != 0 || iq.size() != 0) check("sb_leftover", 20'h1, 20'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
